// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the oversampling UART receiver.
//   uart_state_e : receiver FSM states
//   OVERSAMPLE   : ticks per bit
//   TICK_*       : oversample tick indices used for sampling within a bit
//   maj3         : 2-of-3 majority vote
//   calc_div     : clocks per oversample tick (integer division, minimum 1)
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam logic [3:0] TICK_EARLY = 4'd7;
    localparam logic [3:0] TICK_MID   = 4'd8;
    localparam logic [3:0] TICK_LATE  = 4'd9;
    localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        int unsigned d;
        d = clk_hz / (baud * OVERSAMPLE);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator.
//   CLK     in  clock
//   RST     in  asynchronous active-high reset
//   restart in  realign the tick phase (counter back to 0)
//   tick    out one-cycle pulse every DIV clocks
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x oversampled UART receiver with valid/ready output.
// Frame is 8N1 by default; defining UART_RX_PARITY_EN adds an even-parity bit (8E1).
//   CLK     in  clock, rising edge
//   RST     in  asynchronous active-high reset
//   RXD     in  asynchronous serial line, idle high
//   DATA    out received byte (LSB received first)
//   VALID   out DATA holds an unconsumed byte
//   READY   in  consumer accepts DATA when VALID & READY
//   FERR    out one-cycle pulse: stop bit sampled low
//   OVERRUN out one-cycle pulse: byte completed while previous byte still held
//   PERR    out one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUD        = 115200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FERR,
    output logic       OVERRUN,
    output logic       PERR
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_rx_prev;
    uart_state_e r_state;
    logic [3:0]  r_os_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_s7;
    logic        r_s8;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        r_ovr;

    logic w_rx;
    logic w_start_edge;
    logic w_tick;
    logic w_bit;
    logic w_decide;
    logic w_done;
    logic w_par_bad;

    assign w_rx         = r_sync2;
    assign w_start_edge = (r_state == ST_IDLE) && r_rx_prev && !w_rx;
    // The third vote is the live sample at tick 9, so no extra register is needed.
    assign w_bit        = maj3(r_s7, r_s8, w_rx);
    assign w_decide     = w_tick && (r_os_cnt == TICK_LATE);
    assign w_done       = (r_state == ST_STOP) && w_decide && w_bit && !w_par_bad;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .CLK    (CLK),
        .RST    (RST),
        .restart(w_start_edge),
        .tick   (w_tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= RXD;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_s7      <= 1'b1;
            r_s8      <= 1'b1;
        end else begin
            if (w_start_edge) begin
                r_os_cnt <= '0;
            end else if (w_tick && (r_state != ST_IDLE)) begin
                r_os_cnt <= r_os_cnt + 4'd1;
            end
            if (w_tick && (r_os_cnt == TICK_EARLY)) r_s7 <= w_rx;
            if (w_tick && (r_os_cnt == TICK_MID))   r_s8 <= w_rx;

            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_state   <= ST_START;
                        r_bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    // Reject glitches at mid-bit; otherwise wait out the start bit.
                    if (w_tick && (r_os_cnt == TICK_MID) && w_rx) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick && (r_os_cnt == TICK_LAST)) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_decide) r_state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (w_decide) r_state <= w_bit ? ST_IDLE : ST_BREAK;
                end
                ST_BREAK: begin
                    if (w_rx) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_perr;
    logic w_par_mismatch;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_par_mismatch = (r_state == ST_PARITY) && w_decide && ((^r_shift) ^ w_bit);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_perr <= w_par_mismatch;
            if (w_start_edge) begin
                r_par_bad <= 1'b0;
            end else if (w_par_mismatch) begin
                r_par_bad <= 1'b1;
            end
        end
    end

    assign w_par_bad = r_par_bad;
    assign PERR      = r_perr;
`else
    assign w_par_bad = 1'b0;
    assign PERR      = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= (r_state == ST_STOP) && w_decide && !w_bit;
            r_ovr  <= 1'b0;
            if (w_done) begin
                if (!r_valid || READY) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && READY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign DATA    = r_data;
    assign VALID   = r_valid;
    assign FERR    = r_ferr;
    assign OVERRUN = r_ovr;

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

    localparam int unsigned CLK_HZ   = 7372800;  // 4 clocks per oversample tick
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned BIT_CLKS = CLK_HZ / BAUD;  // 64

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       RXD   = 1'b1;
    logic       READY = 1'b1;
    logic [7:0] DATA;
    logic       VALID;
    logic       FERR;
    logic       OVERRUN;
    logic       PERR;

    int n_checks = 0;
    int n_fail   = 0;

    int   cyc      = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt  = 0;
    int   perr_cnt = 0;
    int   stab_err = 0;
    logic [7:0] acc_q[$];

    uart_rx_oversample #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD       (BAUD)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .RXD    (RXD),
        .DATA   (DATA),
        .VALID  (VALID),
        .READY  (READY),
        .FERR   (FERR),
        .OVERRUN(OVERRUN),
        .PERR   (PERR)
    );

    always #5 CLK = ~CLK;

    // Monitor: count pulses, log accepted bytes, watch DATA stability while stalled.
    initial begin
        logic       prev_stall;
        logic [7:0] held;
        prev_stall = 1'b0;
        held       = 8'h00;
        forever begin
            @(negedge CLK);
            cyc++;
            if (FERR)    ferr_cnt++;
            if (OVERRUN) ovr_cnt++;
            if (PERR)    perr_cnt++;
            if (VALID && READY) acc_q.push_back(DATA);
            if (prev_stall && VALID && (DATA != held)) stab_err++;
            prev_stall = VALID && !READY;
            held       = DATA;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        RXD = b;
        repeat (BIT_CLKS) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ !par_ok);
`endif
        if (stop_ok) begin
            drive_bit(1'b1);
            drive_bit(1'b1);
        end else begin
            drive_bit(1'b0);
            drive_bit(1'b0);
            drive_bit(1'b0);
            drive_bit(1'b1);
            drive_bit(1'b1);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       par_ok;
        logic       exp_byte;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int f0, o0, p0, a0, lat;
        logic seen;
        logic [7:0] exp_q[$];
        int exp_ferr, exp_perr;

        // Reset state
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rst_data", {24'd0, DATA}, 32'h00);
        chk("rst_valid", {31'd0, VALID}, 0);
        chk("rst_pulses", {29'd0, FERR, OVERRUN, PERR}, 0);
        RST = 1'b0;
        drive_bit(1'b1);

        // First byte with VALID latency window and single-cycle VALID
        f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt; a0 = acc_q.size();
        lat  = 0;
        seen = 1'b0;
        fork
            send_frame(8'h61, 1'b1, 1'b1);
            begin
                int c0;
                c0 = cyc;
                for (int i = 0; i < 12 * BIT_CLKS && !seen; i++) begin
                    @(negedge CLK);
                    if (VALID) begin
                        seen = 1'b1;
                        lat  = cyc - c0;
                    end
                end
                if (seen) begin
                    @(negedge CLK);
                    chk("valid_one_cycle", {31'd0, VALID}, 0);
                end
            end
        join
        chk("valid_seen", {31'd0, seen}, 1);
        chk("valid_latency_window",
            {31'd0, (lat >= (BIT_CLKS * 19) / 2) && (lat <= BIT_CLKS * 10)}, 1);
        chk("b61_count", acc_q.size() - a0, 1);
        if (acc_q.size() > a0) chk("b61_data", {24'd0, acc_q[$]}, 32'h61);
        chk("b61_flags", (ferr_cnt - f0) + (ovr_cnt - o0) + (perr_cnt - p0), 0);

        // Glitch of 3/16 bit from idle, then a good byte
        a0 = acc_q.size(); f0 = ferr_cnt;
        RXD = 1'b0;
        repeat ((BIT_CLKS * 3) / 16) @(posedge CLK);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("glitch_no_byte", acc_q.size() - a0, 0);
        chk("glitch_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'hA5, 1'b1, 1'b1);
        chk("after_glitch_count", acc_q.size() - a0, 1);
        if (acc_q.size() > a0) chk("after_glitch_data", {24'd0, acc_q[$]}, 32'hA5);

        // Table-driven frames
        vecs.push_back('{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
`endif
        foreach (vecs[k]) begin
            f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt; a0 = acc_q.size();
            send_frame(vecs[k].data, vecs[k].stop_ok, vecs[k].par_ok);
            chk($sformatf("vec%0d_ferr", k), ferr_cnt - f0, {31'd0, vecs[k].exp_ferr});
            chk($sformatf("vec%0d_perr", k), perr_cnt - p0, {31'd0, vecs[k].exp_perr});
            chk($sformatf("vec%0d_ovr", k), ovr_cnt - o0, 0);
            chk($sformatf("vec%0d_count", k), acc_q.size() - a0, {31'd0, vecs[k].exp_byte});
            if (vecs[k].exp_byte && (acc_q.size() > a0))
                chk($sformatf("vec%0d_data", k), {24'd0, acc_q[$]}, {24'd0, vecs[k].data});
        end

        // Overrun: two bytes while stalled, then one handshake
        READY = 1'b0;
        o0 = ovr_cnt; a0 = acc_q.size(); stab_err = 0;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        chk("ovr_valid_held", {31'd0, VALID}, 1);
        chk("ovr_data_held", {24'd0, DATA}, 32'h11);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_stable", stab_err, 0);
        READY = 1'b1;
        @(posedge CLK); #1;
        chk("ovr_valid_drop", {31'd0, VALID}, 0);
        drive_bit(1'b1);
        chk("ovr_accepted_count", acc_q.size() - a0, 1);
        if (acc_q.size() > a0) chk("ovr_accepted_data", {24'd0, acc_q[$]}, 32'h11);

        // Reset in the middle of data bit 4 of 0xFF
        a0 = acc_q.size(); f0 = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        RXD = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("midrst_valid", {31'd0, VALID}, 0);
        chk("midrst_data", {24'd0, DATA}, 32'h00);
        RST = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h0F, 1'b1, 1'b1);
        chk("midrst_count", acc_q.size() - a0, 1);
        if (acc_q.size() > a0) chk("midrst_data_0f", {24'd0, acc_q[$]}, 32'h0F);
        chk("midrst_ferr", ferr_cnt - f0, 0);

        // Randomized frames against a frame-level model
        a0 = acc_q.size(); f0 = ferr_cnt; p0 = perr_cnt; o0 = ovr_cnt;
        exp_ferr = 0;
        exp_perr = 0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       s_ok;
            logic       p_ok;
            d    = 8'($urandom_range(0, 255));
            s_ok = ($urandom_range(0, 4) != 0);
            p_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
            p_ok = ($urandom_range(0, 4) != 0);
`endif
            if (!s_ok) exp_ferr++;
            if (!p_ok) exp_perr++;
            if (s_ok && p_ok) exp_q.push_back(d);
            send_frame(d, s_ok, p_ok);
        end
        chk("rand_count", acc_q.size() - a0, exp_q.size());
        chk("rand_ferr", ferr_cnt - f0, exp_ferr);
        chk("rand_perr", perr_cnt - p0, exp_perr);
        chk("rand_ovr", ovr_cnt - o0, 0);
        foreach (exp_q[j]) begin
            if (a0 + j < acc_q.size())
                chk($sformatf("rand_data%0d", j), {24'd0, acc_q[a0 + j]}, {24'd0, exp_q[j]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port RXD  input  1  asynchronous serial line, idle high, 8N1 (8E1 with parity).
REQ-006 SHALL have port DATA  output  8  received byte, LSB received first.
REQ-007 SHALL have port VALID  output  1  DATA holds an unconsumed byte.
REQ-008 SHALL have port READY  input  1  consumer accepts DATA when VALID & READY.
REQ-009 SHALL have port FERR  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port OVERRUN  output  1  one-cycle pulse: byte completed while VALID held.
REQ-011 SHALL have port PERR  output  1  one-cycle pulse: parity mismatch.

Function
REQ-012 SHALL pass RXD through a 2-flop synchronizer; both flops reset to 1.
REQ-013 SHALL generate a 16x oversample tick every DIV=CLK_FREQ_HZ/(BAUD*16) clocks (integer division, min 1); tick counter reset on each start-edge detection.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE->START on synchronized RXD 1->0 transition.
REQ-016 START SHALL check the line at oversample tick 8; if high (glitch) -> IDLE with no output, else -> DATA.
REQ-017 Each data/parity/stop bit SHALL be decided by 2-of-3 majority of samples at ticks 7, 8, 9 of that bit; 16 ticks per bit.
REQ-018 DATA SHALL shift 8 bits LSB first, then -> PARITY (macro on) or STOP.
REQ-019 STOP with stop bit 1: byte complete; -> IDLE immediately after the stop-bit decision (no wait for bit end).
REQ-020 STOP with stop bit 0: FERR pulses, byte discarded, -> BREAK; BREAK -> IDLE once synchronized RXD is 1.
REQ-021 On byte complete with VALID=0, or VALID=1 and READY=1 in the same cycle: DATA loads, VALID=1 on the next clock.
REQ-022 On byte complete with VALID=1 and READY=0: OVERRUN pulses, DATA and VALID retained, new byte dropped.
REQ-023 VALID SHALL clear the clock after VALID & READY unless REQ-021 reloads in that cycle.
REQ-024 DATA SHALL be stable while VALID=1 and READY=0.
REQ-025 Latency: VALID rises exactly 1 clock after the cycle containing stop-bit tick 9.

Reset
REQ-026 RST high SHALL force state IDLE, DATA=0x00, VALID=0, FERR=0, OVERRUN=0, PERR=0, counters 0, synchronizer flops 1.
REQ-027 RST mid-frame SHALL abandon the partial byte; the next start edge after RST release begins a fresh frame.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: one even-parity bit follows the data bits; on mismatch PERR pulses, byte discarded, and the stop bit is still checked.
REQ-029 UART_RX_PARITY_EN undefined: no PARITY state, frame is 8N1, PERR tied 0 (port retained).

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum, OVERSAMPLE=16, and the sample-tick constants 7/8/9.
REQ-031 Sub-module uart_baud_tick SHALL generate the oversample tick (parameter DIV, inputs CLK, RST, restart; output tick).

Verification
REQ-032 Byte 0x61 at 115200 baud, READY=1 -> DATA=0x61, VALID high 1 cycle, FERR/OVERRUN/PERR 0.
REQ-033 RXD low pulse of 3 bit-periods/16 from idle -> no VALID, state back to IDLE, next byte 0xA5 received correctly.
REQ-034 Byte 0x3C with stop bit driven 0 then line held low 2 bit times -> FERR one pulse, VALID stays 0, following 0x55 received.
REQ-035 Bytes 0x11 then 0x22 back-to-back with READY=0 -> DATA=0x11 held, OVERRUN one pulse; READY=1 -> VALID drops, no 0x22.
REQ-036 RST asserted at data bit 4 of 0xFF, released, then 0x0F sent -> only DATA=0x0F observed.
REQ-037 With UART_RX_PARITY_EN: 0x07 with parity bit 0 (odd data, wrong parity) -> PERR pulse, no VALID; with parity bit 1 -> DATA=0x07.
